bitty_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the Bitty processor core. Holds a loadable instruction memory and a program counter. Presents one 16-bit instruction at a time on `instruction`, waits for the core's `done` pulse, then advances. Stops at a programmable end address, or on a watchdog timeout if `done` never arrives.

---
 rtl/bitty_fetch_unit_if.sv | 28 ++
 rtl/bitty_fetch_unit.sv | 111 +++++++++++
 tb/tb_bitty_fetch_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_fetch_unit_if.sv
// Signal bundle between the Bitty fetch unit (slave) and its loader/core side (master).
interface bitty_fetch_unit_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic [ADDR_W-1:0] end_addr;
   logic              load_en;
   logic [ADDR_W-1:0] load_addr;
   logic [15:0]       load_data;
   logic              done;
   logic [15:0]       instruction;
   logic              new_inst;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              halted;
   logic              timeout_err;
   logic [15:0]       retired;

   modport master (
      output start, end_addr, load_en, load_addr, load_data, done,
      input  instruction, new_inst, pc, busy, halted, timeout_err, retired
   );

   modport slave (
      input  start, end_addr, load_en, load_addr, load_data, done,
      output instruction, new_inst, pc, busy, halted, timeout_err, retired
   );
endinterface

// File: rtl/bitty_fetch_unit.sv
// Instruction fetch stage for the Bitty core: loadable instruction memory, program
// counter, done-driven sequencing with an end address and a watchdog halt.
module bitty_fetch_unit #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 64
) (
   input logic               clk,
   input logic               reset,
   bitty_fetch_unit_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [15:0]       retired_q, retired_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              tmo_q, tmo_d;
   logic              new_inst_q, new_inst_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;

   logic [15:0] mem_q [DEPTH];

   // No reset on the array: program contents survive a core reset.
   always_ff @(posedge clk) begin
      if (bus.load_en) mem_q[bus.load_addr] <= bus.load_data;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      retired_d  = retired_q;
      wd_d       = wd_q;
      tmo_d      = tmo_q;
      new_inst_d = 1'b0;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               pc_d      = '0;
               retired_d = '0;
               tmo_d     = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            // Read sampled before any same-edge write lands, so a colliding load yields the old word.
            instr_d    = mem_q[pc_q];
            wd_d       = '0;
            new_inst_d = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            if (bus.done) begin
               retired_d = retired_q + 16'd1;
               if (pc_q == bus.end_addr) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = S_FETCH;
               end
            end else if (wd_q == WD_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
      halted_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         retired_q  <= '0;
         wd_q       <= '0;
         tmo_q      <= 1'b0;
         new_inst_q <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         retired_q  <= retired_d;
         wd_q       <= wd_d;
         tmo_q      <= tmo_d;
         new_inst_q <= new_inst_d;
         busy_q     <= busy_d;
         halted_q   <= halted_d;
      end
   end

   assign bus.instruction = instr_q;
   assign bus.new_inst    = new_inst_q;
   assign bus.pc          = pc_q;
   assign bus.busy        = busy_q;
   assign bus.halted      = halted_q;
   assign bus.timeout_err = tmo_q;
   assign bus.retired     = retired_q;
endmodule

// File: tb/tb_bitty_fetch_unit.sv
// Randomized bench for bitty_fetch_unit: a cycle-level behavioural model compared on every cycle,
// plus directed runs with literal expectations (order, counts, wrap, watchdog, reset).
module tb_bitty_fetch_unit;
   localparam int AW    = 2;
   localparam int TO    = 8;
   localparam int DEPTH = 1 << AW;
   localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit   chk_on = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   bitty_fetch_unit_if #(.ADDR_W(AW)) bus ();
   bitty_fetch_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (.clk(clk), .reset(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          m_mode, m_pc, m_ret, m_age;
   bit          m_tmo, m_new;
   logic [15:0] m_instr;
   logic [15:0] m_mem [DEPTH];

   task automatic m_reset();
      m_mode = M_IDLE; m_pc = 0; m_ret = 0; m_age = 0;
      m_tmo = 0; m_new = 0; m_instr = 16'h0000;
   endtask

   task automatic m_step();
      logic [15:0] rd;
      rd    = m_mem[m_pc];
      m_new = 0;
      case (m_mode)
         M_IDLE, M_HALT: if (bus.start) begin
            m_mode = M_FETCH; m_pc = 0; m_ret = 0; m_tmo = 0;
         end
         M_FETCH: begin
            m_instr = rd; m_new = 1; m_age = 0; m_mode = M_EXEC;
         end
         M_EXEC: begin
            m_age++;
            if (bus.done) begin
               m_ret = (m_ret + 1) % 65536;
               if (m_pc == int'(bus.end_addr)) m_mode = M_HALT;
               else begin m_pc = (m_pc + 1) % DEPTH; m_mode = M_FETCH; end
            end else if (m_age == TO) begin
               m_tmo = 1; m_mode = M_HALT;
            end
         end
         default: ;
      endcase
      if (bus.load_en) m_mem[bus.load_addr] = bus.load_data;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else        m_step();
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         chk("instruction", bus.instruction, m_instr);
         chk("new_inst",    bus.new_inst,    m_new);
         chk("pc",          bus.pc,          m_pc);
         chk("busy",        bus.busy,        (m_mode == M_FETCH || m_mode == M_EXEC));
         chk("halted",      bus.halted,      (m_mode == M_HALT));
         chk("timeout_err", bus.timeout_err, m_tmo);
         chk("retired",     bus.retired,     m_ret);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [15:0] seen [$];

   task automatic load(input int a, input logic [15:0] d);
      @(negedge clk);
      bus.load_en = 1'b1; bus.load_addr = AW'(a); bus.load_data = d;
      @(negedge clk);
      bus.load_en = 1'b0;
   endtask

   // Starts a run and plays the core: done follows each new_inst after dly cycles
   // (dly<0: random 0..3 per instruction). sw_end retargets end_addr to 1 at the 3rd
   // instruction; spur adds ignored done/start and loads to the pc being fetched.
   task automatic run(input int dly, input bit sw_end, input bit spur,
                      output int npulse, output int t_first, output int t_halt);
      int cnt;
      seen.delete();
      npulse = 0; t_first = -1; t_halt = -1; cnt = -1;
      @(negedge clk);
      bus.start = 1'b1;
      if (spur) bus.done = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.done = 1'b0; bus.load_en = 1'b0;
         if (bus.halted) begin t_halt = c; break; end
         if (spur && c == 0) bus.done = 1'b1;
         if (bus.new_inst) begin
            seen.push_back(bus.instruction);
            npulse++;
            if (t_first < 0) t_first = c;
            cnt = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            if (sw_end && npulse == 3) bus.end_addr = AW'(1);
         end
         if (cnt == 0) begin
            bus.done = 1'b1; cnt = -1;
         end else if (cnt > 0) begin
            cnt--;
            if (spur) bus.start = 1'b1;
         end
         if (spur && m_mode == M_FETCH) begin
            bus.load_en = 1'b1; bus.load_addr = AW'(m_pc); bus.load_data = 16'($urandom);
         end
      end
      chk("run_halts", (t_halt >= 0), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- test sequence ----------------
   initial begin
      int np, tf, th, sel, dly, nl;
      logic [15:0] exp_seq [4];
      bus.start = 0; bus.end_addr = '0; bus.load_en = 0; bus.load_addr = '0;
      bus.load_data = '0; bus.done = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1; chk_on = 1'b1;
      @(negedge clk);
      chk("reset_instruction", bus.instruction, 16'h0000);
      chk("reset_busy", bus.busy, 0);
      chk("reset_halted", bus.halted, 0);
      chk("reset_retired", bus.retired, 0);

      exp_seq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) load(i, exp_seq[i]);
      bus.end_addr = AW'(3);

      // straight run, done two cycles after each new_inst
      run(2, 0, 0, np, tf, th);
      chk("straight_pulses", np, 4);
      for (int i = 0; i < 4; i++) chk("straight_order", (i < seen.size()) ? seen[i] : 16'hxxxx, exp_seq[i]);
      chk("straight_retired", bus.retired, 4);
      chk("straight_halted", bus.halted, 1);
      chk("straight_pc", bus.pc, 3);

      // back-to-back: done in the first EXEC cycle
      run(0, 0, 0, np, tf, th);
      chk("b2b_pulses", np, 4);
      chk("b2b_retired", bus.retired, 4);

      // spurious done/start and collide loads during FETCH; fetched words stay the old ones
      run(2, 0, 1, np, tf, th);
      for (int i = 0; i < 4; i++) chk("collide_old_word", (i < seen.size()) ? seen[i] : 16'hxxxx, exp_seq[i]);
      chk("spur_retired", bus.retired, 4);
      bus.done = 1'b1;
      repeat (3) @(negedge clk);
      bus.done = 1'b0;
      @(negedge clk);
      chk("halt_done_ignored", bus.retired, 4);

      // wrap-around
      for (int i = 0; i < 4; i++) load(i, 16'($urandom));
      run(-1, 0, 0, np, tf, th);
      chk("wrap0_pc", bus.pc, 3);
      chk("wrap0_retired", bus.retired, 4);
      run(-1, 1, 0, np, tf, th);
      chk("wrap_retired", bus.retired, 6);
      chk("wrap_pc", bus.pc, 1);
      chk("wrap_pulses", np, 6);
      bus.end_addr = AW'(3);

      // watchdog
      run(1000, 0, 0, np, tf, th);
      chk("wd_err", bus.timeout_err, 1);
      chk("wd_retired", bus.retired, 0);
      chk("wd_pc", bus.pc, 0);
      chk("wd_latency", th - tf, TO);
      run(0, 0, 0, np, tf, th);
      chk("wd_cleared", bus.timeout_err, 0);
      chk("wd_after_retired", bus.retired, 4);
      run(TO - 1, 0, 0, np, tf, th);
      chk("expiry_done_err", bus.timeout_err, 0);
      chk("expiry_done_retired", bus.retired, 4);

      // asynchronous reset in the middle of EXEC
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      begin
         bit got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.new_inst) got = 1;
         end
         chk("mid_exec_reached", got, 1);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_instruction", bus.instruction, 16'h0000);
      chk("async_new_inst", bus.new_inst, 0);
      chk("async_pc", bus.pc, 0);
      chk("async_busy", bus.busy, 0);
      chk("async_halted", bus.halted, 0);
      chk("async_timeout_err", bus.timeout_err, 0);
      chk("async_retired", bus.retired, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_instruction", bus.instruction, 16'h0000);
      chk("idle_busy", bus.busy, 0);
      chk("idle_halted", bus.halted, 0);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         nl = $urandom_range(0, 3);
         for (int i = 0; i < nl; i++) load($urandom_range(0, DEPTH - 1), 16'($urandom));
         bus.end_addr = AW'($urandom_range(0, DEPTH - 1));
         sel = $urandom_range(0, 9);
         dly = (sel == 9) ? 1000 : (sel == 8) ? TO - 1 : -1;
         run(dly, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), np, tf, th);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
